dma_read_engine: RTL and testbench

Source-side DMA stage. It accepts one descriptor at a time, splits the transfer into AXI INCR read bursts on the source memory, and writes every returned beat into the read-to-write data FIFO. Each FIFO word is tagged with the `last` and `packet_complete` flags that the downstream write engine uses to close destination bursts and end the packet. FIFO overflow is prevented by credit, so `rready` is tied high.

---
 rtl/dma_read_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_dma_read_engine.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_read_engine.sv
`default_nettype none
// ============================================================================
//  Module      : dma_read_engine
//  Description : Source-side DMA read stage. Splits one descriptor into AXI
//                INCR read bursts and tags returned beats for the data FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_read_engine #(
    parameter int DATA_W     = 512,
    parameter int ADDR_W     = 64,
    parameter int LENGTH_W   = 20,
    parameter int AXI_LEN_W  = 4,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          desc_valid,
    output logic                          desc_ready,
    input  logic [ADDR_W-1:0]             desc_src_addr,
    input  logic [LENGTH_W-1:0]           desc_length,
    output logic                          arvalid,
    input  logic                          arready,
    output logic [ADDR_W-1:0]             araddr,
    output logic [7:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    input  logic                          rvalid,
    output logic                          rready,
    input  logic [DATA_W-3:0]             rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast,
    output logic                          fifo_wr_en,
    output logic [DATA_W-1:0]             fifo_wr_data,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rd_fsm_done,
    output logic                          busy,
    output logic                          rd_err,
    output logic [LENGTH_W-1:0]           beat_cnt
);

    localparam int c_PAY_W     = DATA_W - 2;
    localparam int c_SIZE      = $clog2(c_PAY_W / 8);
    localparam int c_MAX_BEATS = 2 ** AXI_LEN_W;
    localparam int c_CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int c_SUM_W     = ((c_CNT_W > LENGTH_W) ? c_CNT_W : LENGTH_W) + 2;
    localparam logic [ADDR_W-1:0] c_ADDR_MASK =
        ~((ADDR_W'(1) << c_SIZE) - ADDR_W'(1));

    localparam logic [2:0] c_ST_IDLE        = 3'd0;
    localparam logic [2:0] c_ST_ISSUE       = 3'd1;
    localparam logic [2:0] c_ST_WAIT_CREDIT = 3'd2;
    localparam logic [2:0] c_ST_DRAIN       = 3'd3;
    localparam logic [2:0] c_ST_DONE        = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [ADDR_W-1:0]   r_next_addr;
    logic [ADDR_W-1:0]   r_araddr;
    logic [LENGTH_W-1:0] r_length;
    logic [LENGTH_W-1:0] r_remaining;
    logic [LENGTH_W-1:0] r_beat_cnt;
    logic [c_CNT_W-1:0]  r_reserved;
    logic                r_arvalid;
    logic [7:0]          r_arlen;
    logic                r_fifo_wr_en;
    logic [DATA_W-1:0]   r_fifo_wr_data;
    logic                r_rd_err;

    logic                w_accept;
    logic [LENGTH_W-1:0] w_burst;
    logic                w_credit_ok;
    logic                w_ar_hs;
    logic                w_issue;
    logic [LENGTH_W-1:0] w_beat_k;
    logic                w_last;
    logic                w_pkt_done;

    assign w_accept = desc_valid && (r_state == c_ST_IDLE);
    assign w_burst  = (r_remaining < LENGTH_W'(c_MAX_BEATS)) ? r_remaining
                                                             : LENGTH_W'(c_MAX_BEATS);
    // Outstanding reservations plus current occupancy must leave room for the burst
    assign w_credit_ok = (c_SUM_W'(r_reserved) + c_SUM_W'(fifo_count) + c_SUM_W'(w_burst))
                         <= c_SUM_W'(FIFO_DEPTH);
    assign w_ar_hs  = r_arvalid && arready;
    assign w_issue  = ((r_state == c_ST_ISSUE) || (r_state == c_ST_WAIT_CREDIT)) &&
                      !r_arvalid && w_credit_ok && (r_remaining != '0);

    assign w_beat_k   = r_beat_cnt + LENGTH_W'(1);
    assign w_pkt_done = (w_beat_k == r_length);
    assign w_last     = (w_beat_k[AXI_LEN_W-1:0] == '0) || w_pkt_done;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (desc_valid) begin
                    w_state_next = (desc_length == '0) ? c_ST_DONE : c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                if (r_arvalid) begin
                    if (arready && (r_remaining == w_burst)) begin
                        w_state_next = c_ST_DRAIN;
                    end
                end else if (!w_credit_ok) begin
                    w_state_next = c_ST_WAIT_CREDIT;
                end
            end
            c_ST_WAIT_CREDIT: begin
                if (w_credit_ok) begin
                    w_state_next = c_ST_ISSUE;
                end
            end
            c_ST_DRAIN: begin
                if (r_beat_cnt == r_length) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        desc_ready  = 1'b0;
        busy        = 1'b1;
        rd_fsm_done = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                desc_ready = 1'b1;
                busy       = 1'b0;
            end
            c_ST_DONE: begin
                rd_fsm_done = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // AR channel: address generation and burst bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_next_addr <= '0;
            r_length    <= '0;
            r_remaining <= '0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_arlen     <= '0;
        end else if (w_accept) begin
            r_next_addr <= desc_src_addr & c_ADDR_MASK;
            r_length    <= desc_length;
            r_remaining <= desc_length;
        end else if (w_ar_hs) begin
            r_arvalid   <= 1'b0;
            r_next_addr <= r_next_addr + (ADDR_W'(w_burst) << c_SIZE);
            r_remaining <= r_remaining - w_burst;
        end else if (w_issue) begin
            r_arvalid <= 1'b1;
            r_araddr  <= r_next_addr;
            r_arlen   <= 8'(w_burst - LENGTH_W'(1));
        end
    end

    // FIFO credit: a beat leaves the reservation as it enters fifo_count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reserved <= '0;
        end else begin
            r_reserved <= r_reserved
                        + (w_ar_hs ? c_CNT_W'(w_burst) : c_CNT_W'(0))
                        - (r_fifo_wr_en ? c_CNT_W'(1) : c_CNT_W'(0));
        end
    end

    // R channel: every beat is written and tagged from the running beat count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fifo_wr_en   <= 1'b0;
            r_fifo_wr_data <= '0;
            r_beat_cnt     <= '0;
            r_rd_err       <= 1'b0;
        end else begin
            r_fifo_wr_en <= rvalid;
            if (rvalid) begin
                r_fifo_wr_data <= {w_pkt_done, w_last, rdata};
                r_beat_cnt     <= w_beat_k;
                if (rresp[1]) begin
                    r_rd_err <= 1'b1;
                end
            end
            if (w_accept) begin
                r_beat_cnt <= '0;
                r_rd_err   <= 1'b0;
            end
        end
    end

    assign arvalid      = r_arvalid;
    assign araddr       = r_araddr;
    assign arlen        = r_arlen;
    assign arsize       = 3'(c_SIZE);
    assign arburst      = 2'b01;
    assign rready       = 1'b1;
    assign fifo_wr_en   = r_fifo_wr_en;
    assign fifo_wr_data = r_fifo_wr_data;
    assign rd_err       = r_rd_err;
    assign beat_cnt     = r_beat_cnt;

    logic w_unused;
    assign w_unused = rlast;

endmodule
`default_nettype wire

// File: tb/tb_dma_read_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_read_engine
//  Description : Directed self-checking bench for dma_read_engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_read_engine;

    logic         clk = 1'b0;
    logic         reset;
    logic         desc_valid;
    logic         desc_ready;
    logic [63:0]  desc_src_addr;
    logic [19:0]  desc_length;
    logic         arvalid;
    logic         arready;
    logic [63:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         rvalid;
    logic         rready;
    logic [509:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         fifo_wr_en;
    logic [511:0] fifo_wr_data;
    logic [6:0]   fifo_count;
    logic         rd_fsm_done;
    logic         busy;
    logic         rd_err;
    logic [19:0]  beat_cnt;

    int pass_n  = 0;
    int total_n = 0;
    int ar_n    = 0;
    int wr_n    = 0;
    int done_n  = 0;
    logic [17:0] wr_log [0:255];

    always #5 clk = ~clk;

    dma_read_engine dut (
        .clk           (clk),
        .reset         (reset),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .desc_src_addr (desc_src_addr),
        .desc_length   (desc_length),
        .arvalid       (arvalid),
        .arready       (arready),
        .araddr        (araddr),
        .arlen         (arlen),
        .arsize        (arsize),
        .arburst       (arburst),
        .rvalid        (rvalid),
        .rready        (rready),
        .rdata         (rdata),
        .rresp         (rresp),
        .rlast         (rlast),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_data  (fifo_wr_data),
        .fifo_count    (fifo_count),
        .rd_fsm_done   (rd_fsm_done),
        .busy          (busy),
        .rd_err        (rd_err),
        .beat_cnt      (beat_cnt)
    );

    always @(posedge clk) if (arvalid && arready) ar_n++;

    always @(negedge clk) begin
        if (fifo_wr_en && wr_n < 256) begin
            wr_log[wr_n] = {fifo_wr_data[511:510], fifo_wr_data[15:0]};
            wr_n++;
        end
        if (rd_fsm_done) done_n++;
    end

    task automatic start_desc(input logic [63:0] addr, input logic [19:0] len);
        desc_valid    = 1'b1;
        desc_src_addr = addr;
        desc_length   = len;
        @(negedge clk);
        desc_valid    = 1'b0;
    endtask

    task automatic wait_arvalid(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (arvalid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total_n++;
            $display("FAIL %s: arvalid got 0 want 1 within 50 cycles", name);
        end
    endtask

    task automatic ar_handshake();
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
    endtask

    task automatic send_beats(input int first, input int n, input int err_k);
        for (int i = 0; i < n; i++) begin
            rdata       = '0;
            rdata[15:0] = 16'(first + i);
            rresp       = ((first + i) == err_k) ? 2'd2 : 2'd0;
            rvalid      = 1'b1;
            @(negedge clk);
        end
        rvalid = 1'b0;
        rresp  = 2'd0;
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rd_fsm_done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total_n++;
            $display("FAIL %s: rd_fsm_done got 0 want 1 within 200 cycles", name);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        total_n++;
        if ({desc_ready, busy, arvalid, rready, fifo_wr_en, rd_fsm_done, rd_err} !== 7'b1001000)
            $display("FAIL reset_flags: got %b want 1001000",
                     {desc_ready, busy, arvalid, rready, fifo_wr_en, rd_fsm_done, rd_err});
        else pass_n++;
        total_n++;
        if ({arsize, arburst} !== {3'd6, 2'b01})
            $display("FAIL reset_ar_const: got %h/%b want 6/01", arsize, arburst);
        else pass_n++;
        total_n++;
        if ({beat_cnt, arlen} !== 28'd0 || araddr !== 64'd0)
            $display("FAIL reset_regs: got beat_cnt %0d arlen %0d araddr %h want 0", beat_cnt, arlen, araddr);
        else pass_n++;
    endtask

    task automatic test_single();
        int ar0 = ar_n;
        start_desc(64'h1000, 20'd1);
        total_n++;
        if (busy !== 1'b1 || desc_ready !== 1'b0)
            $display("FAIL single_busy: got busy %b ready %b want 1 0", busy, desc_ready);
        else pass_n++;
        wait_arvalid("single_ar");
        total_n++;
        if (araddr !== 64'h1000 || arlen !== 8'd0)
            $display("FAIL single_ar: got %h/%0d want 1000/0", araddr, arlen);
        else pass_n++;
        ar_handshake();
        send_beats(1, 1, 0);
        total_n++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_data[511:510] !== 2'b11 || fifo_wr_data[15:0] !== 16'd1)
            $display("FAIL single_word: got en %b flags %b pay %0d want 1 11 1",
                     fifo_wr_en, fifo_wr_data[511:510], fifo_wr_data[15:0]);
        else pass_n++;
        total_n++;
        if (rd_fsm_done !== 1'b0) $display("FAIL single_done_early: got %b want 0", rd_fsm_done);
        else pass_n++;
        @(negedge clk);
        total_n++;
        if (rd_fsm_done !== 1'b1) $display("FAIL single_done: got %b want 1", rd_fsm_done);
        else pass_n++;
        @(negedge clk);
        total_n++;
        if (desc_ready !== 1'b1 || rd_fsm_done !== 1'b0)
            $display("FAIL single_idle: got ready %b done %b want 1 0", desc_ready, rd_fsm_done);
        else pass_n++;
        total_n++;
        if (ar_n - ar0 !== 1) $display("FAIL single_ar_count: got %0d want 1", ar_n - ar0);
        else pass_n++;
    endtask

    task automatic test_back_to_back();
        int w0 = wr_n;
        logic [63:0] exp_addr;
        logic [7:0]  exp_len;
        logic [17:0] exp;
        start_desc(64'h0, 20'd40);
        for (int b = 0; b < 3; b++) begin
            wait_arvalid("b2b_ar");
            exp_addr = 64'h400 * b;
            exp_len  = (b < 2) ? 8'd15 : 8'd7;
            total_n++;
            if (araddr !== exp_addr || arlen !== exp_len)
                $display("FAIL b2b_ar%0d: got %h/%0d want %h/%0d", b, araddr, arlen, exp_addr, exp_len);
            else pass_n++;
            ar_handshake();
            if (b < 2) begin
                total_n++;
                if (arvalid !== 1'b0) $display("FAIL b2b_gap%0d: got %b want 0", b, arvalid);
                else pass_n++;
                @(negedge clk);
                total_n++;
                if (arvalid !== 1'b1) $display("FAIL b2b_next%0d: got %b want 1", b, arvalid);
                else pass_n++;
            end
        end
        send_beats(1, 40, 0);
        total_n++;
        if (beat_cnt !== 20'd40) $display("FAIL b2b_beat_cnt: got %0d want 40", beat_cnt);
        else pass_n++;
        wait_done("b2b_done");
        total_n++;
        if (wr_n - w0 !== 40) $display("FAIL b2b_wr_count: got %0d want 40", wr_n - w0);
        else pass_n++;
        for (int k = 1; k <= 40; k++) begin
            exp = {(k == 40), ((k % 16) == 0) || (k == 40), k[15:0]};
            total_n++;
            if (wr_log[w0 + k - 1] !== exp)
                $display("FAIL b2b_word%0d: got %h want %h", k, wr_log[w0 + k - 1], exp);
            else pass_n++;
        end
    endtask

    task automatic test_credit_stall();
        bit held = 1'b1;
        bit stable = 1'b1;
        int ar0;
        fifo_count = 7'd56;
        start_desc(64'h4000, 20'd16);
        for (int i = 0; i < 5; i++) begin
            if (arvalid !== 1'b0) held = 1'b0;
            @(negedge clk);
        end
        total_n++;
        if (held !== 1'b1 || busy !== 1'b1) $display("FAIL credit_hold: got held %b busy %b want 1 1", held, busy);
        else pass_n++;
        fifo_count = 7'd48;
        @(negedge clk);
        total_n++;
        if (arvalid !== 1'b1 || arlen !== 8'd15 || araddr !== 64'h4000)
            $display("FAIL credit_release: got %b %0d %h want 1 15 4000", arvalid, arlen, araddr);
        else pass_n++;
        for (int i = 0; i < 10; i++) begin
            if (arvalid !== 1'b1 || arlen !== 8'd15 || araddr !== 64'h4000) stable = 1'b0;
            @(negedge clk);
        end
        total_n++;
        if (stable !== 1'b1) $display("FAIL stall_stable: got %b want 1", stable);
        else pass_n++;
        ar0 = ar_n;
        ar_handshake();
        repeat (3) @(negedge clk);
        total_n++;
        if (ar_n - ar0 !== 1 || arvalid !== 1'b0)
            $display("FAIL stall_one_hs: got %0d hs arvalid %b want 1 0", ar_n - ar0, arvalid);
        else pass_n++;
        fifo_count = 7'd0;
        send_beats(1, 16, 0);
        wait_done("stall_done");
    endtask

    task automatic test_error();
        int w0 = wr_n;
        start_desc(64'h2011, 20'd8);
        wait_arvalid("err_ar");
        total_n++;
        if (araddr !== 64'h2000 || arlen !== 8'd7)
            $display("FAIL err_ar: got %h/%0d want 2000/7", araddr, arlen);
        else pass_n++;
        ar_handshake();
        send_beats(1, 2, 3);
        total_n++;
        if (rd_err !== 1'b0) $display("FAIL err_before: got %b want 0", rd_err);
        else pass_n++;
        send_beats(3, 6, 3);
        total_n++;
        if (rd_err !== 1'b1) $display("FAIL err_set: got %b want 1", rd_err);
        else pass_n++;
        wait_done("err_done");
        total_n++;
        if (wr_n - w0 !== 8 || rd_err !== 1'b1)
            $display("FAIL err_all_written: got %0d words rd_err %b want 8 1", wr_n - w0, rd_err);
        else pass_n++;
    endtask

    task automatic test_zero_length();
        int ar0 = ar_n;
        int w0  = wr_n;
        int d0  = done_n;
        start_desc(64'h8000, 20'd0);
        total_n++;
        if (rd_fsm_done !== 1'b1 || rd_err !== 1'b0)
            $display("FAIL zero_done: got done %b rd_err %b want 1 0", rd_fsm_done, rd_err);
        else pass_n++;
        @(negedge clk);
        total_n++;
        if (desc_ready !== 1'b1 || rd_fsm_done !== 1'b0)
            $display("FAIL zero_idle: got ready %b done %b want 1 0", desc_ready, rd_fsm_done);
        else pass_n++;
        repeat (3) @(negedge clk);
        total_n++;
        if (ar_n - ar0 !== 0 || wr_n - w0 !== 0 || done_n - d0 !== 1)
            $display("FAIL zero_counts: got ar %0d wr %0d done %0d want 0 0 1", ar_n - ar0, wr_n - w0, done_n - d0);
        else pass_n++;
    endtask

    task automatic test_reset_mid();
        start_desc(64'h0, 20'd32);
        wait_arvalid("rst_ar");
        ar_handshake();
        send_beats(1, 5, 0);
        total_n++;
        if (beat_cnt !== 20'd5 || fifo_wr_en !== 1'b1 || arvalid !== 1'b1)
            $display("FAIL rst_pre: got cnt %0d en %b arvalid %b want 5 1 1", beat_cnt, fifo_wr_en, arvalid);
        else pass_n++;
        reset = 1'b1;
        #1;
        total_n++;
        if ({arvalid, desc_ready, busy, fifo_wr_en, rd_fsm_done, rd_err, rready} !== 7'b0100001)
            $display("FAIL rst_mid_flags: got %b want 0100001",
                     {arvalid, desc_ready, busy, fifo_wr_en, rd_fsm_done, rd_err, rready});
        else pass_n++;
        total_n++;
        if (beat_cnt !== 20'd0 || araddr !== 64'd0 || arlen !== 8'd0 || fifo_wr_data !== 512'd0)
            $display("FAIL rst_mid_regs: got cnt %0d araddr %h arlen %0d want 0", beat_cnt, araddr, arlen);
        else pass_n++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total_n++;
        if (desc_ready !== 1'b1 || arvalid !== 1'b0)
            $display("FAIL rst_after: got ready %b arvalid %b want 1 0", desc_ready, arvalid);
        else pass_n++;
    endtask

    initial begin
        reset         = 1'b1;
        desc_valid    = 1'b0;
        desc_src_addr = '0;
        desc_length   = '0;
        arready       = 1'b0;
        rvalid        = 1'b0;
        rdata         = '0;
        rresp         = 2'd0;
        rlast         = 1'b0;
        fifo_count    = 7'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_credit_stall();
        test_error();
        test_zero_length();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
`default_nettype wire
